// File: rtl/life_step_engine.sv
// rtl/life_step_engine.sv - In-place Conway B3/S23 torus generation sequencer
//
// Advances a board held in HEIGHT external row registers by one generation
// per start request, using a 3-row sliding window (prev/cur/nxt) plus a saved
// copy of original row 0 so every row can be overwritten in place.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   start      request one generation step (sampled only while idle)
//   rd_addr    row being read this cycle
//   rd_data    contents of row rd_addr, combinational
//   wr_addr    row being written this cycle
//   wr_data    next-state row (bit c = column c)
//   we         write strobe for row wr_addr
//   busy       high from the first prime cycle through the last row write
//   done       one-cycle pulse after the last row write
//   generation completed generations since reset (wraps)

module life_step_engine #(
    parameter int WIDTH  = 11,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [$clog2(HEIGHT)-1:0] rd_addr,
    input  logic [WIDTH-1:0]          rd_data,
    output logic [$clog2(HEIGHT)-1:0] wr_addr,
    output logic [WIDTH-1:0]          wr_data,
    output logic                      we,
    output logic                      busy,
    output logic                      done,
    output logic [GEN_W-1:0]          generation
);

    localparam int AW = $clog2(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME0,
        S_PRIME1,
        S_PRIME2,
        S_STEP,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    row;
    logic [AW:0]      row_plus2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] row0_save;
    logic [WIDTH-1:0] next_row;

    // One B3/S23 row update with column wrap-around.
    function automatic logic [WIDTH-1:0] life_row(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH-1:0] res;
        logic [3:0]       cnt;
        int               l;
        int               rr;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            l   = (i == 0) ? WIDTH - 1 : i - 1;
            rr  = (i == WIDTH - 1) ? 0 : i + 1;
            cnt = 4'(p[l]) + 4'(p[i]) + 4'(p[rr])
                + 4'(c[l])             + 4'(c[rr])
                + 4'(n[l]) + 4'(n[i]) + 4'(n[rr]);
            res[i] = (cnt == 4'd3) | (c[i] & (cnt == 4'd2));
        end
        return res;
    endfunction

    assign next_row  = life_row(prev, cur, nxt);
    assign row_plus2 = {1'b0, row} + (AW+1)'(2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            row        <= '0;
            prev       <= '0;
            cur        <= '0;
            nxt        <= '0;
            row0_save  <= '0;
            generation <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_PRIME0: prev <= rd_data;
                S_PRIME1: begin
                    cur       <= rd_data;
                    row0_save <= rd_data;
                end
                S_PRIME2: begin
                    nxt <= rd_data;
                    row <= '0;
                end
                S_STEP: begin
                    prev <= cur;
                    cur  <= nxt;
                    // Row 0 was overwritten in the first STEP, so the wrap
                    // neighbour for the last row comes from the saved copy.
                    nxt  <= (row == AW'(HEIGHT - 2)) ? row0_save : rd_data;
                    row  <= row + 1'b1;
                end
                S_DONE: generation <= generation + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        we       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_PRIME0;
            end
            S_PRIME0: begin
                busy     = 1'b1;
                rd_addr  = AW'(HEIGHT - 1);
                state_nx = S_PRIME1;
            end
            S_PRIME1: begin
                busy     = 1'b1;
                state_nx = S_PRIME2;
            end
            S_PRIME2: begin
                busy     = 1'b1;
                rd_addr  = AW'(1);
                state_nx = S_STEP;
            end
            S_STEP: begin
                busy    = 1'b1;
                we      = 1'b1;
                wr_addr = row;
                wr_data = next_row;
                if (row_plus2 < (AW+1)'(HEIGHT)) rd_addr = row_plus2[AW-1:0];
                if (row == AW'(HEIGHT - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_life_step_engine.sv
// tb/tb_life_step_engine.sv - Self-checking bench for life_step_engine
module tb_life_step_engine;

    localparam int W  = 11;
    localparam int H  = 8;
    localparam int GW = 16;
    localparam int AW = 3;

    typedef logic [H-1:0][W-1:0] board_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          we;
    logic          busy;
    logic          done;
    logic [GW-1:0] generation;

    board_t board;
    board_t ld_board;
    logic   ld = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    int            m_phase = 0;
    logic [GW-1:0] m_gen = '0;
    board_t        m_next = '0;

    always #5 clk = ~clk;

    life_step_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
        .busy(busy), .done(done), .generation(generation)
    );

    // Row register bank with combinational read port.
    assign rd_data = board[rd_addr];
    always @(posedge clk) begin
        if (ld) board <= ld_board;
        else if (we) board[wr_addr] <= wr_data;
    end

    // Whole-board reference generation on a torus.
    function automatic board_t life(input board_t b);
        board_t o;
        int n;
        o = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(b[(r + dr + H) % H][(c + dc + W) % W]);
                o[r][c] = (n == 3) || (b[r][c] && n == 2);
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Timeline model: phase k = k-th cycle after the accepting start edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_gen   <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_next  <= life(board);
            end
        end else if (m_phase == H + 4) begin
            m_phase <= 0;
            m_gen   <= m_gen + 1'b1;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    logic          e_busy, e_we, e_done;
    logic [AW-1:0] e_wa, e_ra;
    logic [W-1:0]  e_wd;
    int            e_r;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = (m_phase >= 1) && (m_phase <= H + 3);
            e_we   = (m_phase >= 4) && (m_phase <= H + 3);
            e_done = (m_phase == H + 4);
            e_wa   = '0;
            e_wd   = '0;
            e_ra   = '0;
            if (m_phase == 1) e_ra = AW'(H - 1);
            else if (m_phase == 3) e_ra = AW'(1);
            if (e_we) begin
                e_r  = m_phase - 4;
                e_wa = AW'(e_r);
                e_wd = m_next[e_r];
                if (e_r + 2 < H) e_ra = AW'(e_r + 2);
            end
            chk("busy", busy, e_busy);
            chk("we", we, e_we);
            chk("done", done, e_done);
            chk("wr_addr", wr_addr, e_wa);
            chk("wr_data", wr_data, e_wd);
            chk("rd_addr", rd_addr, e_ra);
            chk("generation", generation, m_gen);
        end
    end

    task automatic load(input board_t b);
        @(negedge clk);
        ld_board = b;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run_step(output int done_k, output int we_n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_k = -1;
        we_n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (we) we_n++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    board_t b_blink, b_blink_next, b_corner, b_lone, b_partial, b_snap;
    int dk, wn, cnt;

    initial begin
        b_blink = '0;
        b_blink[3] = 11'b00000011100;
        b_blink_next = '0;
        b_blink_next[2] = 11'b00000001000;
        b_blink_next[3] = 11'b00000001000;
        b_blink_next[4] = 11'b00000001000;
        b_corner = '0;
        b_corner[0] = 11'b10000000001;
        b_corner[7] = 11'b10000000001;
        b_lone = '0;
        b_lone[5] = 11'b00000100000;
        b_partial = '0;
        b_partial[2] = 11'b00000001000;
        b_partial[3] = 11'b00000001000;

        // Reset held with start high: everything quiet.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_gen", generation, 0);
        start = 1'b0;
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (we || busy) cnt++;
        end
        chk("idle_no_activity", cnt, 0);

        // Blinker, two steps.
        load(b_blink);
        run_step(dk, wn);
        chk("blink_done_cycle", dk, 12);
        chk("blink_we_cycles", wn, 8);
        chk("blink_gen1", generation, 1);
        chk("blink_board1", board, b_blink_next);
        run_step(dk, wn);
        chk("blink_board2", board, b_blink);
        chk("blink_gen2", generation, 2);

        // Corner block across both wraps.
        load(b_corner);
        run_step(dk, wn);
        chk("corner_board", board, b_corner);

        // Lone cell dies; empty stays empty.
        load(b_lone);
        run_step(dk, wn);
        chk("lone_board", board, 0);
        run_step(dk, wn);
        chk("empty_board", board, 0);
        chk("gen_before_hold", generation, 5);

        // start held high across two full periods: one done per idle visit.
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        repeat (26) begin
            @(negedge clk);
            if (done) cnt++;
        end
        start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("hold_done_count", cnt, 2);
        chk("hold_gen", generation, 7);

        // Reset during STEP r=4.
        load(b_blink);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_we", we, 0);
        chk("midrst_gen", generation, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_board", board, b_partial);
        b_snap = board;
        run_step(dk, wn);
        chk("after_rst_done_cycle", dk, 12);
        chk("after_rst_board", board, life(b_snap));
        chk("after_rst_gen", generation, 1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
